// File: rtl/axi_stream_input.sv
// AXI4-Stream ingress: writes each accepted beat as one SRAM word from a programmable base,
// counting kept int8 elements against an expected size and flagging size/tlast mismatches.
module axi_stream_input #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SRAM_WIDTH     = 64,
  parameter int unsigned MAX_ADDR_WIDTH = 13,
  localparam int unsigned LANES         = SRAM_WIDTH / DATA_WIDTH
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_aresetn,
  input  logic [SRAM_WIDTH-1:0]     s_axis_tdata,
  input  logic [LANES-1:0]          s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic                      start_input,
  input  logic [MAX_ADDR_WIDTH-1:0] in_size,
  input  logic [MAX_ADDR_WIDTH-1:0] base_addr,
  output logic                      sram_in_en,
  output logic                      sram_in_we,
  output logic [MAX_ADDR_WIDTH-1:0] sram_in_addr,
  output logic [SRAM_WIDTH-1:0]     sram_in_data,
  output logic [MAX_ADDR_WIDTH:0]   elem_count,
  output logic                      input_done,
  output logic                      input_error
);

  localparam int unsigned CntW = MAX_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e                    r_state, w_state_next;
  logic                      r_tready, r_done, r_error, r_sram_en;
  logic [MAX_ADDR_WIDTH-1:0] r_size, r_base, r_beat_cnt, r_sram_addr;
  logic [SRAM_WIDTH-1:0]     r_sram_data;
  logic [CntW-1:0]           r_elem_count;

  logic [SRAM_WIDTH-1:0]     w_masked;
  logic [3:0]                w_pop;
  logic [CntW:0]             w_next, w_size_ext;
  logic [CntW-1:0]           w_elem_sat;
  logic                      w_accept, w_ge, w_gt, w_term, w_err;

  always_comb begin
    w_masked = '0;
    w_pop    = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (s_axis_tkeep[i]) begin
        w_masked[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      w_pop = w_pop + {3'b000, s_axis_tkeep[i]};
    end
  end

  // One extra bit on the running sum so overshoot and saturation are both visible.
  assign w_next     = {1'b0, r_elem_count} + {{(CntW - 3){1'b0}}, w_pop};
  assign w_size_ext = {2'b00, r_size};
  assign w_ge       = (w_next >= w_size_ext);
  assign w_gt       = (w_next > w_size_ext);
  assign w_elem_sat = w_next[CntW] ? '1 : w_next[CntW-1:0];
  assign w_accept   = s_axis_tvalid && r_tready;
  assign w_term     = s_axis_tlast || w_ge;
  assign w_err      = (s_axis_tlast && !w_ge) || (!s_axis_tlast && w_ge) || w_gt;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start_input) begin
          w_state_next = (in_size == '0) ? StDone : StRecv;
        end
      end
      StRecv: begin
        if (w_accept && w_term) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (!start_input) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_tready     <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_sram_en    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_data  <= '0;
      r_size       <= '0;
      r_base       <= '0;
      r_beat_cnt   <= '0;
      r_elem_count <= '0;
    end else begin
      r_tready  <= (w_state_next == StRecv);
      r_done    <= (w_state_next == StDone);
      r_sram_en <= 1'b0;
      if ((r_state == StIdle) && start_input) begin
        r_size       <= in_size;
        r_base       <= base_addr;
        r_beat_cnt   <= '0;
        r_elem_count <= '0;
        r_error      <= 1'b0;
      end
      if (w_accept) begin
        r_sram_en    <= 1'b1;
        r_sram_addr  <= r_base + r_beat_cnt;
        r_sram_data  <= w_masked;
        r_beat_cnt   <= r_beat_cnt + 1'b1;
        r_elem_count <= w_elem_sat;
        if (w_term) begin
          r_error <= w_err;
        end
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign sram_in_en    = r_sram_en;
  assign sram_in_we    = r_sram_en;
  assign sram_in_addr  = r_sram_addr;
  assign sram_in_data  = r_sram_data;
  assign elem_count    = r_elem_count;
  assign input_done    = r_done;
  assign input_error   = r_error;

endmodule

// File: tb/tb_axi_stream_input.sv
// Directed self-checking bench for axi_stream_input with hand-computed expectations.
module tb_axi_stream_input;

  logic        clk, rst_n;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tready, tlast;
  logic        start;
  logic [12:0] size, base;
  logic        en, we;
  logic [12:0] addr;
  logic [63:0] wdata;
  logic [13:0] elem;
  logic        done, err;

  int n_checks = 0;
  int n_errors = 0;

  axi_stream_input dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tdata   (tdata),
    .s_axis_tkeep   (tkeep),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tlast   (tlast),
    .start_input    (start),
    .in_size        (size),
    .base_addr      (base),
    .sram_in_en     (en),
    .sram_in_we     (we),
    .sram_in_addr   (addr),
    .sram_in_data   (wdata),
    .elem_count     (elem),
    .input_done     (done),
    .input_error    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, 64'(tready), 64'd0);
    check({tag, "_en"},     64'(en),     64'd0);
    check({tag, "_we"},     64'(we),     64'd0);
    check({tag, "_addr"},   64'(addr),   64'd0);
    check({tag, "_data"},   wdata,       64'd0);
    check({tag, "_elem"},   64'(elem),   64'd0);
    check({tag, "_done"},   64'(done),   64'd0);
    check({tag, "_err"},    64'(err),    64'd0);
  endtask

  task automatic start_pkt(input logic [12:0] s, input logic [12:0] b);
    start = 1'b1;
    size  = s;
    base  = b;
    tick();
    check("start_tready", 64'(tready), 64'd1);
    check("start_elem",   64'(elem),   64'd0);
    check("start_err",    64'(err),    64'd0);
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                      input logic [12:0] ea, input logic [63:0] ed, input logic [13:0] ee);
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tick();
    check("wr_en",   64'(en),   64'd1);
    check("wr_we",   64'(we),   64'd1);
    check("wr_addr", 64'(addr), 64'(ea));
    check("wr_data", wdata,     ed);
    check("elem",    64'(elem), 64'(ee));
  endtask

  task automatic finish_pkt(input logic exp_err, input logic [13:0] exp_elem);
    tvalid = 1'b0;
    tlast  = 1'b0;
    check("end_done",   64'(done),   64'd1);
    check("end_tready", 64'(tready), 64'd0);
    check("end_err",    64'(err),    64'(exp_err));
    check("end_elem",   64'(elem),   64'(exp_elem));
    tick();
    check("hold_en",   64'(en),   64'd0);
    check("hold_done", 64'(done), 64'd1);
    start = 1'b0;
    tick();
    check("rel_done", 64'(done), 64'd0);
    check("rel_err",  64'(err),  64'(exp_err));
  endtask

  initial begin
    logic [15:0] pat;
    int          k;
    rst_n = 1'b1; tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0;
    start = 1'b0; size = '0; base = '0;
    #2 rst_n = 1'b0;
    #2 check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Two full beats, tlast on the second.
    start_pkt(13'd16, 13'h100);
    beat(64'h0807060504030201, 8'hFF, 1'b0, 13'h100, 64'h0807060504030201, 14'd8);
    check("t1_done_mid", 64'(done), 64'd0);
    beat(64'hF8F7F6F5F4F3F2F1, 8'hFF, 1'b1, 13'h101, 64'hF8F7F6F5F4F3F2F1, 14'd16);
    finish_pkt(1'b0, 14'd16);

    // Partial final beat zeroes the upper lanes.
    start_pkt(13'd12, 13'h020);
    beat(64'h8877665544332211, 8'hFF, 1'b0, 13'h020, 64'h8877665544332211, 14'd8);
    beat(64'hFFEEDDCCBBAA9988, 8'h0F, 1'b1, 13'h021, 64'h00000000BBAA9988, 14'd12);
    finish_pkt(1'b0, 14'd12);

    // Short packet.
    start_pkt(13'd24, 13'h000);
    beat(64'h1111111111111111, 8'hFF, 1'b0, 13'h000, 64'h1111111111111111, 14'd8);
    beat(64'h2222222222222222, 8'hFF, 1'b1, 13'h001, 64'h2222222222222222, 14'd16);
    finish_pkt(1'b1, 14'd16);

    // Long packet: size reached without tlast; upstream keeps tvalid high.
    start_pkt(13'd8, 13'h040);
    beat(64'h3333333333333333, 8'hFF, 1'b0, 13'h040, 64'h3333333333333333, 14'd8);
    tdata = 64'h4444444444444444;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("long_no_wr", 64'(en),     64'd0);
      check("long_tready", 64'(tready), 64'd0);
      check("long_elem",  64'(elem),   64'd8);
    end
    finish_pkt(1'b1, 14'd8);

    // Sparse tkeep then overshoot of the expected size.
    start_pkt(13'd10, 13'h060);
    beat(64'h1122334455667788, 8'hA5, 1'b0, 13'h060, 64'h1100330000660088, 14'd4);
    beat(64'h9999999999999999, 8'hFF, 1'b0, 13'h061, 64'h9999999999999999, 14'd12);
    finish_pkt(1'b1, 14'd12);

    // Address wraps at the top of the SRAM.
    start_pkt(13'd16, 13'h1FFF);
    beat(64'h5555555555555555, 8'hFF, 1'b0, 13'h1FFF, 64'h5555555555555555, 14'd8);
    beat(64'h6666666666666666, 8'hFF, 1'b1, 13'h0000, 64'h6666666666666666, 14'd16);
    finish_pkt(1'b0, 14'd16);

    // Zero size goes straight to done.
    start = 1'b1; size = 13'd0; base = 13'h123;
    tick();
    check("zero_done",   64'(done),   64'd1);
    check("zero_tready", 64'(tready), 64'd0);
    check("zero_en",     64'(en),     64'd0);
    finish_pkt(1'b0, 14'd0);

    // tvalid gaps: five beats under a fixed pattern.
    start_pkt(13'd40, 13'h050);
    pat = 16'b1010_0110_1011_0010;
    k = 0;
    for (int c = 0; c < 16 && k < 5; c++) begin
      tvalid = pat[c];
      tdata  = 64'h0101010101010101 * 64'(k + 1);
      tkeep  = 8'hFF;
      tlast  = (k == 4);
      tick();
      if (pat[c]) begin
        check("gap_en",   64'(en),   64'd1);
        check("gap_addr", 64'(addr), 64'(13'h050 + 13'(k)));
        check("gap_data", wdata,     64'h0101010101010101 * 64'(k + 1));
        check("gap_elem", 64'(elem), 64'(8 * (k + 1)));
        k++;
      end else begin
        check("gap_stall_en", 64'(en), 64'd0);
      end
    end
    check("gap_beats", 64'(k), 64'd5);
    finish_pkt(1'b0, 14'd40);

    // Asynchronous reset mid-packet, then a clean packet.
    start_pkt(13'd24, 13'h200);
    beat(64'h7777777777777777, 8'hFF, 1'b0, 13'h200, 64'h7777777777777777, 14'd8);
    tdata = 64'h8888888888888888;
    #2 rst_n = 1'b0;
    #1 check_all_zero("arst");
    tick();
    check("arst_no_wr", 64'(en), 64'd0);
    tvalid = 1'b0; start = 1'b0;
    rst_n = 1'b1;
    tick();
    check_all_zero("post_rst");
    start_pkt(13'd8, 13'h300);
    beat(64'hABCDEF0123456789, 8'hFF, 1'b1, 13'h300, 64'hABCDEF0123456789, 14'd8);
    finish_pkt(1'b0, 14'd8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_stream_input.md
Name: axi_stream_input

Overview:
- Ingress stage of the NPU datapath. Accepts an AXI4-Stream slave packet of packed signed int8 elements and writes each beat as one word into the input SRAM, starting at a programmable base address.
- Counts received elements against an expected size. Reports done and error status to the controller, which then starts compute; compute results are later drained by the output streamer.

Parameters:
- DATA_WIDTH, 8, width of one element.
- SRAM_WIDTH, 64, SRAM word and stream beat width. LANES = SRAM_WIDTH/DATA_WIDTH = 8.
- MAX_ADDR_WIDTH, 13, SRAM address width; also the width of the size and count fields.

Ports:
- s_axis_aclk  in  1  single clock.
- s_axis_aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  SRAM_WIDTH  packed elements; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  LANES  per-lane valid; 1 bit per element.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accept.
- s_axis_tlast  in  1  last beat of packet.
- start_input  in  1  level request from controller.
- in_size  in  MAX_ADDR_WIDTH  expected element count.
- base_addr  in  MAX_ADDR_WIDTH  first SRAM word address.
- sram_in_en  out  1  SRAM enable.
- sram_in_we  out  1  SRAM write enable.
- sram_in_addr  out  MAX_ADDR_WIDTH  write address.
- sram_in_data  out  SRAM_WIDTH  write data.
- elem_count  out  MAX_ADDR_WIDTH+1  elements received so far.
- input_done  out  1  packet complete.
- input_error  out  1  size/tlast mismatch.

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs 0: tready, sram_in_en, sram_in_we, sram_in_addr, sram_in_data, elem_count, input_done, input_error. Asserting reset mid-packet aborts immediately; nothing further is written.
- s_axis_tready is a registered state decode: 1 only in RECV.
- IDLE:
  - When start_input=1, latch in_size and base_addr; clear beat_cnt, elem_count and input_error.
  - Go to RECV, or directly to DONE if in_size==0 (done with no writes, no error).
- RECV: a beat is accepted when s_axis_tvalid && s_axis_tready. One cycle after acceptance:
  - sram_in_en=sram_in_we=1 for exactly one cycle.
  - sram_in_addr = base_addr + beat_cnt, modulo 2^MAX_ADDR_WIDTH (wraps, no error).
  - sram_in_data = tdata with every lane whose tkeep=0 forced to zero.
  - beat_cnt increments.
  - elem_count += popcount(tkeep).
- RECV exit: let next = elem_count + popcount(tkeep). Exit to DONE when tlast=1 or next >= in_size.
  - s_axis_tready falls in the cycle after the terminating beat. No beat is accepted after termination.
  - input_error=1 if tlast && next<in_size (short packet).
  - input_error=1 if !tlast && next>=in_size (long packet; the remainder stays unconsumed in the upstream).
  - input_error=1 if next>in_size (overshoot); that beat is still written.
- Non-contiguous tkeep is legal: it is counted by popcount and its zero-keep lanes are zeroed.
- DONE: input_done=1 and held while start_input=1. When start_input falls, input_done clears, state goes to IDLE, and input_error holds its value until the next start.
- Deasserting start_input during RECV does not abort reception; the block finishes the packet first.
- tvalid low in RECV means a stall: no write and no count change.
- Latency: acceptance to SRAM write is 1 cycle. The terminating beat's write and input_done=1 occur in the same cycle.
- Width rules: the popcount result is 4 bits, zero-extended. elem_count saturates at all-ones.

Test Plan:
- in_size=16, base_addr=0x100, two beats with full tkeep, tlast on beat 2, tvalid continuous:
  - writes 0x100 and 0x101, each 1 cycle after acceptance;
  - elem_count=16, input_done=1, input_error=0;
  - tready low the cycle after beat 2.
- in_size=12, second beat tkeep=8'h0F with tlast:
  - lanes 4-7 of the word at base+1 are written as 0;
  - elem_count=12, no error.
- in_size=24, tlast on beat 2 (16 elements) -> DONE, input_error=1, elem_count=16.
- in_size=8, tlast never asserted, tvalid held high -> exactly one beat accepted, input_error=1, tready=0 afterwards.
- Random tvalid gaps (50% duty) with in_size=40 -> 5 writes at consecutive addresses and correct data; no write during stall cycles.
- Reset asserted after beat 1 of 3 -> all outputs 0 asynchronously. After release, a new start with in_size=8 completes normally at base_addr.
